multiband_playback: RTL and testbench

- Parametrised successor to the single-band ROM playback blocks.
- Plays NUM_BANDS band sample tables from one shared external synchronous ROM. Per band: play/stop control, loop or one-shot mode, and an unsigned gain.
- On each 44 kHz enable strobe, reads, scales, sums and saturates one sample from every band. Emits one mixed sample with a valid pulse.
- Runs on the 4.4 MHz audio clock and feeds the output/mixer stage.

---
 rtl/multiband_playback.sv | 115 +++++++++++
 tb/tb_multiband_playback.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiband_playback.sv
// multiband_playback: mixes NUM_BANDS ROM sample tables per frame strobe with per-band gain, loop/one-shot control and saturation.
module multiband_playback #(
  parameter int NUM_BANDS = 10,
  parameter int DATA_W = 16,
  parameter int MEM_DEPTH = 4036,
  parameter int ADDR_W = $clog2(MEM_DEPTH),
  parameter int GAIN_W = 8,
  parameter int BAND_W = NUM_BANDS > 1 ? $clog2(NUM_BANDS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_BANDS-1:0]        start,
  input  logic [NUM_BANDS-1:0]        stop,
  input  logic [NUM_BANDS-1:0]        loop_mode,
  input  logic [NUM_BANDS*GAIN_W-1:0] gain,
  output logic                        rom_en,
  output logic [BAND_W-1:0]           rom_band,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic signed [DATA_W-1:0]    rom_data,
  output logic signed [DATA_W-1:0]    data_out,
  output logic                        valid_out,
  output logic [NUM_BANDS-1:0]        done,
  output logic                        busy,
  output logic                        overrun
);
  localparam int ACC_W = DATA_W + GAIN_W + BAND_W + 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MAC, OUT} state_t;
  state_t state, state_n;
  logic [BAND_W-1:0] k;
  logic [ADDR_W-1:0] ptr [NUM_BANDS];
  logic [GAIN_W-1:0] gains [NUM_BANDS];
  logic [NUM_BANDS-1:0] active, pend_start, pend_stop, done_acc;
  logic signed [DATA_W-1:0] sample, sat_n;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, acc_n, shifted;
  logic accept, last, wrap;
  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_gain
    assign gains[g] = gain[g*GAIN_W +: GAIN_W];
  end
  assign accept = enable && state == IDLE;
  assign last = k == BAND_W'(NUM_BANDS - 1);
  assign wrap = ptr[k] == ADDR_W'(MEM_DEPTH - 1);
  assign prod = sample * $signed({1'b0, gains[k]});
  assign acc_n = active[k] ? acc + ACC_W'(prod) : acc;
  assign shifted = acc_n >>> (GAIN_W - 1);
  assign sat_n = shifted > SAT_MAX ? DATA_W'(SAT_MAX) : shifted < SAT_MIN ? DATA_W'(SAT_MIN) : shifted[DATA_W-1:0];
  assign busy = state != IDLE;
  assign rom_en = state == ISSUE;
  assign rom_band = k;
  assign rom_addr = ptr[k];
  // data_out is loaded on the way into OUT so the valid/done pulse and the new sample line up
  assign valid_out = state == OUT;
  assign done = valid_out ? done_acc : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = enable ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = MAC;
      MAC:     state_n = last ? OUT : ISSUE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      active <= '0;
      pend_start <= '0;
      pend_stop <= '0;
      done_acc <= '0;
      sample <= '0;
      acc <= '0;
      data_out <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) ptr[i] <= '0;
    end else begin
      state <= state_n;
      pend_start <= accept ? '0 : pend_start | start;
      pend_stop <= accept ? '0 : pend_stop | stop;
      if (enable && busy) overrun <= 1'b1;
      if (accept) begin
        acc <= '0;
        k <= '0;
        done_acc <= '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
          if (pend_stop[i] || stop[i]) begin
            active[i] <= 1'b0;
            ptr[i] <= '0;
          end else if (pend_start[i] || start[i]) begin
            active[i] <= 1'b1;
            ptr[i] <= '0;
          end
        end
      end
      if (state == WAIT) sample <= rom_data;
      if (state == MAC) begin
        acc <= acc_n;
        k <= last ? '0 : k + 1'b1;
        if (last) data_out <= sat_n;
        if (active[k]) begin
          ptr[k] <= wrap ? '0 : ptr[k] + 1'b1;
          if (wrap && !loop_mode[k]) begin
            active[k] <= 1'b0;
            done_acc[k] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_multiband_playback.sv
// tb_multiband_playback: randomized and directed checks of two playback instances (full depth and depth 8) against a frame-level mixing model.
module tb_multiband_playback;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [9:0] start = '0, stop = '0, loop_mode = '0;
  logic [79:0] gain = '0;
  logic rom_en, rom8_en, valid_out, valid8, busy, busy8, overrun, overrun8;
  logic [3:0] rom_band, rom8_band;
  logic [11:0] rom_addr;
  logic [2:0] rom8_addr;
  logic signed [15:0] rom_data = '0, rom8_data = '0, data_out, data8, force_val = '0, got;
  logic [9:0] done, done8;
  bit rom_force = 0;
  int total = 0, bad = 0;
  int m_ptr [2][10];
  bit m_act [2][10];
  bit [9:0] m_ps, m_pst;

  multiband_playback dut (.clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .loop_mode(loop_mode), .gain(gain), .rom_en(rom_en), .rom_band(rom_band), .rom_addr(rom_addr),
    .rom_data(rom_data), .data_out(data_out), .valid_out(valid_out), .done(done), .busy(busy), .overrun(overrun));
  multiband_playback #(.MEM_DEPTH(8)) dut8 (.clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .loop_mode(loop_mode), .gain(gain), .rom_en(rom8_en), .rom_band(rom8_band), .rom_addr(rom8_addr),
    .rom_data(rom8_data), .data_out(data8), .valid_out(valid8), .done(done8), .busy(busy8), .overrun(overrun8));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_force ? force_val : 16'(rom_band * 1000 + rom_addr);
    if (rom8_en) rom8_data <= rom_force ? force_val : 16'(rom8_band * 1000 + rom8_addr);
  end

  function automatic int rom_val(int b, int a);
    return rom_force ? int'(force_val) : b * 1000 + a;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) for (int b = 0; b < 10; b++) begin m_act[d][b] = 0; m_ptr[d][b] = 0; end
    m_ps = '0; m_pst = '0;
  endtask

  task automatic model_apply();
    for (int d = 0; d < 2; d++) for (int b = 0; b < 10; b++)
      if (m_pst[b]) begin m_act[d][b] = 0; m_ptr[d][b] = 0; end
      else if (m_ps[b]) begin m_act[d][b] = 1; m_ptr[d][b] = 0; end
    m_ps = '0; m_pst = '0;
  endtask

  task automatic model_frame(input int d, output int res, output bit [9:0] dn);
    longint sum = 0, r;
    int depth = d ? 8 : 4036;
    dn = '0;
    for (int b = 0; b < 10; b++) if (m_act[d][b]) begin
      int gv = int'(gain[b*8 +: 8]);
      sum += longint'(rom_val(b, m_ptr[d][b])) * gv;
      if (m_ptr[d][b] == depth - 1) begin
        m_ptr[d][b] = 0;
        if (!loop_mode[b]) begin m_act[d][b] = 0; dn[b] = 1; end
      end else m_ptr[d][b]++;
    end
    r = sum >>> 7;
    res = r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
  endtask

  task automatic pulse(input logic [9:0] sm, input logic [9:0] pm);
    @(negedge clk); start = sm; stop = pm; m_ps |= sm; m_pst |= pm;
    @(negedge clk); start = '0; stop = '0;
  endtask

  task automatic run_frame(input int extra_at, output logic signed [15:0] g);
    int res0, res1, lat = 0;
    bit [9:0] dn0, dn1;
    int bands[$];
    bit ok;
    model_apply();
    model_frame(0, res0, dn0);
    model_frame(1, res1, dn1);
    @(negedge clk); enable = 1;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      enable = (i == extra_at);
      if (rom_en) bands.push_back(int'(rom_band));
      if (valid_out) lat = i;
    end
    total++; if (lat != 31) begin bad++; $display("FAIL latency: got %0d want 31", lat); end
    ok = bands.size() == 10;
    foreach (bands[j]) if (bands[j] != j) ok = 0;
    total++; if (!ok) begin bad++; $display("FAIL rom_band_seq: got %p want 0..9", bands); end
    total++; if (data_out !== 16'(res0)) begin bad++; $display("FAIL data_out: got %0d want %0d", data_out, res0); end
    total++; if (done !== dn0) begin bad++; $display("FAIL done: got %b want %b", done, dn0); end
    total++; if (valid8 !== 1'b1 || data8 !== 16'(res1)) begin bad++; $display("FAIL data8: got %0d/%b want %0d/1", data8, valid8, res1); end
    total++; if (done8 !== dn1) begin bad++; $display("FAIL done8: got %b want %b", done8, dn1); end
    g = data_out;
    @(negedge clk);
    total++; if ({valid_out, busy, done} !== '0) begin bad++; $display("FAIL post_frame: got valid=%b busy=%b done=%b want 0", valid_out, busy, done); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({data_out, valid_out, done, busy, overrun, rom_en, rom_band, rom_addr, data8, valid8, done8, busy8, overrun8} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h/%h want 0", {data_out, valid_out, done, busy, overrun, rom_en, rom_band, rom_addr}, {data8, valid8, done8});
    end
    rst = 0;
    model_reset();
  endtask

  task automatic test_single_band();
    gain = {10{8'd128}}; loop_mode = '1;
    pulse(10'b1 << 3, '0);
    for (int i = 0; i < 3; i++) begin
      run_frame(0, got);
      total++; if (got !== 16'(3000 + i)) begin bad++; $display("FAIL band3_sample: got %0d want %0d", got, 3000 + i); end
    end
  endtask

  task automatic test_two_bands();
    pulse('0, '1); run_frame(0, got);
    gain[15:8] = 8'd64; gain[23:16] = 8'd255;
    pulse(10'b110, '0);
    for (int i = 0; i < 5; i++) run_frame(0, got);
    total++; if (got !== 16'sd4494) begin bad++; $display("FAIL two_band_mix: got %0d want 4494", got); end
  endtask

  task automatic test_saturation();
    gain = {10{8'd255}};
    pulse('1, '0);
    rom_force = 1; force_val = 16'sd32767;
    run_frame(0, got);
    total++; if (got !== 16'sd32767) begin bad++; $display("FAIL sat_pos: got %0d want 32767", got); end
    force_val = -16'sd32768;
    run_frame(0, got);
    total++; if (got !== -16'sd32768) begin bad++; $display("FAIL sat_neg: got %0d want -32768", got); end
    rom_force = 0;
  endtask

  task automatic test_oneshot();
    pulse('0, '1); run_frame(0, got);
    gain = {10{8'd128}}; loop_mode = '0;
    pulse(10'b1, '0);
    for (int i = 0; i < 9; i++) run_frame(0, got);
    loop_mode[0] = 1;
    pulse(10'b1, '0);
    for (int i = 0; i < 9; i++) run_frame(0, got);
  endtask

  task automatic test_start_stop();
    pulse('0, '1); run_frame(0, got);
    gain = {10{8'd128}}; loop_mode = '1;
    pulse(10'b1 << 5, '0);
    for (int i = 0; i < 100; i++) run_frame(0, got);
    pulse(10'b1 << 5, '0);
    run_frame(0, got);
    total++; if (got !== 16'sd5000) begin bad++; $display("FAIL restart_addr0: got %0d want 5000", got); end
    pulse(10'b1 << 5, '0);
    pulse('0, 10'b1 << 5);
    run_frame(0, got);
    total++; if (got !== 16'sd0) begin bad++; $display("FAIL stop_wins: got %0d want 0", got); end
  endtask

  task automatic test_overrun();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    pulse(10'b1001, '0);
    run_frame(10, got);
    total++; if (overrun !== 1'b1 || overrun8 !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b%b want 11", overrun, overrun8); end
    repeat (5) @(negedge clk);
    run_frame(0, got);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_random();
    logic [95:0] r;
    for (int it = 0; it < 20; it++) begin
      r = {$urandom(), $urandom(), $urandom()};
      gain = r[79:0];
      loop_mode = 10'($urandom());
      if ($urandom_range(0, 3) != 0) pulse(10'($urandom()), 10'($urandom() & $urandom() & $urandom()));
      run_frame(0, got);
    end
  endtask

  task automatic test_reset_midframe();
    bit seen = 0;
    gain = {10{8'd64}}; loop_mode = '1;
    pulse('1, '0); run_frame(0, got);
    @(negedge clk); enable = 1;
    @(negedge clk); enable = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    total++;
    if ({data_out, valid_out, done, busy, overrun, rom_en, rom_band, rom_addr} !== '0) begin
      bad++; $display("FAIL reset_midframe: got %h want 0", {data_out, valid_out, done, busy, overrun, rom_en, rom_band, rom_addr});
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (valid_out || valid8) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL no_valid_after_reset: got 1 want 0"); end
    pulse('1, '0);
    run_frame(0, got);
    total++; if (got !== 16'sd22500) begin bad++; $display("FAIL post_reset_sum: got %0d want 22500", got); end
  endtask

  initial begin
    test_reset();
    test_single_band();
    test_two_bands();
    test_saturation();
    test_oneshot();
    test_start_stop();
    test_overrun();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
